// File: rtl/demux_stream_if.sv
// demux_stream_if: producer-side and per-channel consumer-side stream signals of demux_stream.
// The DUT connects through the slave modport; the driving side uses master.
interface demux_stream_if #(
    parameter int N_OUT  = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3
);
    logic [DATA_W-1:0]       in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_bcast;
    logic                    in_valid;
    logic                    in_ready;
    logic [N_OUT*DATA_W-1:0] out_data;
    logic [N_OUT-1:0]        out_valid;
    logic [N_OUT-1:0]        out_ready;

    modport slave (
        input  in_data, in_sel, in_bcast, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
    modport master (
        output in_data, in_sel, in_bcast, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-N valid/ready demultiplexer with unicast, broadcast and out-of-range sink.
// Optional DEMUX_STREAM_SELERR_EN adds sticky sel_err and saturating 16-bit drop_cnt.
module demux_stream #(
    parameter int N_OUT  = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    demux_stream_if.slave  s
`ifdef DEMUX_STREAM_SELERR_EN
    ,
    output logic           sel_err,
    output logic [15:0]    drop_cnt
`endif
);
    logic [N_OUT-1:0]        valid_q, valid_d;
    logic [N_OUT*DATA_W-1:0] data_q, data_d;
    logic [N_OUT-1:0]        free, hit, tgt, load;
    logic                    accept;

    // an out-of-range in_sel shifts the one-hot to zero, so the sink needs no separate range check
    always_comb begin
        free   = ~valid_q | s.out_ready;
        hit    = N_OUT'(1) << s.in_sel;
        tgt    = s.in_bcast ? {N_OUT{1'b1}} : hit;
        accept = s.in_valid & s.in_ready;
        load   = {N_OUT{accept}} & tgt;
        valid_d = (valid_q & ~s.out_ready) | load;
        data_d = data_q;
        for (int i = 0; i < N_OUT; i++)
            data_d[i*DATA_W +: DATA_W] = load[i] ? s.in_data : data_q[i*DATA_W +: DATA_W];
    end

    assign s.in_ready  = &(free | ~tgt);
    assign s.out_valid = valid_q;
    assign s.out_data  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

`ifdef DEMUX_STREAM_SELERR_EN
    logic        drop, sel_err_q, sel_err_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop       = accept & ~s.in_bcast & ~|hit;
        sel_err_d  = sel_err_q | drop;
        drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            sel_err_q  <= sel_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign sel_err  = sel_err_q;
    assign drop_cnt = drop_cnt_q;
`endif
endmodule
